// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI-Lite request arbiter.
// Holds the FSM encoding, the AXI response codes and a modulo index helper.
package axilite_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_ISSUE    = 2'b01,
        ARB_WAIT_RSP = 2'b10
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Modulo-n addition for operands already below n, without a divider.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/axilite_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate requests so rr_ptr lands at bit 0,
// take the lowest set bit, then rotate the index back to requester numbering.
module rr_arbiter
    import axilite_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_any,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     pick_s;

    // Rotate, priority-pick the lowest rotated bit, rotate the pick back.
    always_comb begin
        dbl_s  = {req_valid, req_valid} >> rr_ptr;
        rot_s  = dbl_s[NUM_REQ-1:0];
        pick_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pick_s = rot_s[i] ? IDX_W'(i) : pick_s;
        end
        grant_any    = |rot_s;
        grant_idx    = IDX_W'(wrap_add(32'(pick_s), 32'(rr_ptr), 32'(NUM_REQ)));
        grant_onehot = grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx)
                                 : {NUM_REQ{1'b0}};
    end

endmodule

// File: rtl/axilite_req_arbiter.sv
// Round-robin front end sharing one AXI-Lite master user port between NUM_REQ
// requesters, with a single transaction outstanding at a time.
module axilite_req_arbiter
    import axilite_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 64,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_w_r,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [1:0]                rsp_status,
    output logic [IDX_W-1:0]          rsp_idx,
    output logic                      mst_start,
    output logic                      mst_w_r,
    output logic [ADDR_W-1:0]         mst_addr,
    output logic [DATA_W-1:0]         mst_data,
    output logic [STRB_W-1:0]         mst_strb,
    input  logic                      mst_free,
    input  logic                      mst_rsp_valid,
    input  logic [DATA_W-1:0]         mst_rsp_data,
    input  logic [1:0]                mst_rsp_status
);

    arb_state_e          state_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic                mst_rsp_valid_q_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic [1:0]          rsp_status_r;
    logic [IDX_W-1:0]    rsp_idx_r;
    logic                mst_start_r;
    logic                mst_w_r_r;
    logic [ADDR_W-1:0]   mst_addr_r;
    logic [DATA_W-1:0]   mst_data_r;
    logic [STRB_W-1:0]   mst_strb_r;

    logic                grant_any_s;
    logic [NUM_REQ-1:0]  gnt_onehot_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic                grant_fire_s;
    logic                completion_s;
    logic [NUM_REQ-1:0]  rsp_onehot_s;
    logic [IDX_W-1:0]    rr_next_s;
    logic                sel_w_r_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [STRB_W-1:0]   sel_strb_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr_r),
        .grant_any    (grant_any_s),
        .grant_onehot (gnt_onehot_s),
        .grant_idx    (gnt_idx_s)
    );

    // Grant qualification, accept strobe and completion edge detect.
    always_comb begin
        grant_fire_s = (state_r == ARB_IDLE) && mst_free && grant_any_s && !areset;
        if (grant_fire_s) begin
            req_ready = gnt_onehot_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        // The master holds its valid as a level, so only a fresh rise means done.
        completion_s = mst_rsp_valid && !mst_rsp_valid_q_r;
        rsp_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
        rr_next_s    = IDX_W'(wrap_add(32'(grant_idx_r), 32'd1, 32'(NUM_REQ)));
    end

    // Payload of the requester currently winning arbitration.
    always_comb begin
        sel_w_r_s  = req_w_r[gnt_idx_s];
        sel_addr_s = req_addr[32'(gnt_idx_s) * ADDR_W +: ADDR_W];
        sel_data_s = req_data[32'(gnt_idx_s) * DATA_W +: DATA_W];
        sel_strb_s = req_strb[32'(gnt_idx_s) * STRB_W +: STRB_W];
    end

    // Arbiter FSM with registered master-side and response-side outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r           <= ARB_IDLE;
            rr_ptr_r          <= '0;
            grant_idx_r       <= '0;
            mst_rsp_valid_q_r <= 1'b0;
            rsp_valid_r       <= '0;
            rsp_data_r        <= '0;
            rsp_status_r      <= RESP_OKAY;
            rsp_idx_r         <= '0;
            mst_start_r       <= 1'b0;
            mst_w_r_r         <= 1'b0;
            mst_addr_r        <= '0;
            mst_data_r        <= '0;
            mst_strb_r        <= '0;
        end else begin
            mst_rsp_valid_q_r <= mst_rsp_valid;
            rsp_valid_r       <= '0;
            case (state_r)
                ARB_IDLE: begin
                    if (grant_fire_s) begin
                        grant_idx_r <= gnt_idx_s;
                        mst_w_r_r   <= sel_w_r_s;
                        mst_addr_r  <= sel_addr_s;
                        mst_data_r  <= sel_data_s;
                        mst_strb_r  <= sel_strb_s;
                        mst_start_r <= 1'b1;
                        state_r     <= ARB_ISSUE;
                    end else begin
                        mst_start_r <= 1'b0;
                        state_r     <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    mst_start_r <= 1'b0;
                    state_r     <= ARB_WAIT_RSP;
                end
                ARB_WAIT_RSP: begin
                    mst_start_r <= 1'b0;
                    if (completion_s) begin
                        rsp_valid_r  <= rsp_onehot_s;
                        rsp_idx_r    <= grant_idx_r;
                        rsp_data_r   <= mst_w_r_r ? mst_rsp_data : {DATA_W{1'b0}};
                        rsp_status_r <= mst_rsp_status;
                        rr_ptr_r     <= rr_next_s;
                        state_r      <= ARB_IDLE;
                    end else begin
                        state_r      <= ARB_WAIT_RSP;
                    end
                end
                default: begin
                    mst_start_r <= 1'b0;
                    state_r     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_status = rsp_status_r;
    assign rsp_idx    = rsp_idx_r;
    assign mst_start  = mst_start_r;
    assign mst_w_r    = mst_w_r_r;
    assign mst_addr   = mst_addr_r;
    assign mst_data   = mst_data_r;
    assign mst_strb   = mst_strb_r;

endmodule

// File: tb/tb_axilite_req_arbiter.sv
// Self-checking bench: random requesters and a behavioural master, scored
// against a transaction-level round-robin reference model.
module tb_axilite_req_arbiter;
    import axilite_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int IDX_W   = 2;
    localparam int STRB_W  = 8;
    localparam int MODE_HOLD = 0;
    localparam int MODE_ALL  = 1;
    localparam int MODE_RAND = 2;

    logic                      aclk = 1'b0;
    logic                      areset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_w_r = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ*STRB_W-1:0] req_strb = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [1:0]                rsp_status;
    logic [IDX_W-1:0]          rsp_idx;
    logic                      mst_start;
    logic                      mst_w_r;
    logic [ADDR_W-1:0]         mst_addr;
    logic [DATA_W-1:0]         mst_data;
    logic [STRB_W-1:0]         mst_strb;
    logic                      mst_free = 1'b1;
    logic                      mst_rsp_valid = 1'b0;
    logic [DATA_W-1:0]         mst_rsp_data = '0;
    logic [1:0]                mst_rsp_status = 2'b00;

    always #5 aclk = ~aclk;

    axilite_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .req_valid      (req_valid),
        .req_w_r        (req_w_r),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_strb       (req_strb),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_status     (rsp_status),
        .rsp_idx        (rsp_idx),
        .mst_start      (mst_start),
        .mst_w_r        (mst_w_r),
        .mst_addr       (mst_addr),
        .mst_data       (mst_data),
        .mst_strb       (mst_strb),
        .mst_free       (mst_free),
        .mst_rsp_valid  (mst_rsp_valid),
        .mst_rsp_data   (mst_rsp_data),
        .mst_rsp_status (mst_rsp_status)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          mode = MODE_HOLD;
    bit          free_rand = 1'b0;
    bit          fix_rsp = 1'b0;
    int          fix_lat = 0;
    logic [DATA_W-1:0] fix_data = '0;
    logic [1:0]        fix_stat = 2'b00;

    // Reference model: one transaction in flight, pointer after the last owner.
    int                m_ptr = 0;
    bit                m_busy = 1'b0;
    int                m_owner = 0;
    bit                m_rd = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [STRB_W-1:0] m_strb = '0;
    bit                exp_start = 1'b0;
    bit                rsp_pending = 1'b0;
    bit                rsp_arm = 1'b0;
    logic [DATA_W-1:0] rsp_exp_data = '0;
    logic [1:0]        rsp_exp_stat = 2'b00;
    int                mm_state = 0;
    int                mm_cnt = 0;
    logic [NUM_REQ-1:0] acc_last = '0;
    int                n_rsp = 0;
    int                grant_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input bit rd, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        req_valid[i] = 1'b1;
        req_w_r[i]   = rd;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
        req_strb[i*STRB_W +: STRB_W] = s;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), {$urandom, $urandom},
                STRB_W'($urandom));
    endtask

    task automatic pre();
        @(negedge aclk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_last[i]) req_valid[i] = 1'b0;
        end
        acc_last = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mode == MODE_ALL) begin
                if (!req_valid[i]) rand_req(i);
            end else if (mode == MODE_RAND) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rand_req(i);
                end
            end
        end
    endtask

    task automatic master_drive();
        case (mm_state)
            1: begin
                mst_rsp_valid = 1'b0;
                mst_free = 1'b0;
                mm_cnt = fix_rsp ? fix_lat : int'($urandom_range(0, 12));
                mm_state = 2;
            end
            2: begin
                if (mm_cnt > 0) begin
                    mm_cnt--;
                end else begin
                    mst_rsp_data   = fix_rsp ? fix_data : {$urandom, $urandom};
                    mst_rsp_status = fix_rsp ? fix_stat : 2'($urandom);
                    mst_rsp_valid  = 1'b1;
                    mst_free       = 1'b1;
                    rsp_exp_data   = m_rd ? mst_rsp_data : '0;
                    rsp_exp_stat   = mst_rsp_status;
                    rsp_pending    = 1'b1;
                    mm_state       = 0;
                end
            end
            default: mst_free = free_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        endcase
    endtask

    task automatic check_cycle();
        logic [NUM_REQ-1:0] exp_ready;
        int win;
        if (rsp_arm) begin
            chk("rsp_valid", rsp_valid, onehot(m_owner));
            chk("rsp_idx", rsp_idx, m_owner);
            chk("rsp_data", rsp_data, rsp_exp_data);
            chk("rsp_status", rsp_status, rsp_exp_stat);
            m_busy = 1'b0;
            m_ptr = (m_owner + 1) % NUM_REQ;
            n_rsp++;
        end else begin
            chk("rsp_valid_idle", rsp_valid, '0);
        end
        rsp_arm = rsp_pending;
        rsp_pending = 1'b0;
        chk("mst_start", mst_start, exp_start);
        if (exp_start) begin
            chk("mst_w_r", mst_w_r, m_rd);
            chk("mst_addr", mst_addr, m_addr);
            chk("mst_data", mst_data, m_data);
            chk("mst_strb", mst_strb, m_strb);
        end
        if (mst_start) mm_state = 1;
        exp_start = 1'b0;
        exp_ready = '0;
        win = -1;
        if (!m_busy && mst_free) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        if (win >= 0) exp_ready = onehot(win);
        chk("req_ready", req_ready, exp_ready);
        if (win >= 0) begin
            m_busy = 1'b1;
            m_owner = win;
            m_rd = req_w_r[win];
            m_addr = req_addr[win*ADDR_W +: ADDR_W];
            m_data = req_data[win*DATA_W +: DATA_W];
            m_strb = req_strb[win*STRB_W +: STRB_W];
            exp_start = 1'b1;
            acc_last = exp_ready;
            grant_q.push_back(win);
        end
    endtask

    task automatic post();
        master_drive();
        #1;
        check_cycle();
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic wait_rsp(input int cnt, input int budget);
        int start;
        int c;
        start = n_rsp;
        c = 0;
        while (n_rsp < start + cnt && c < budget) begin
            step();
            c++;
        end
        chk("rsp_count", n_rsp - start, cnt);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((m_busy || rsp_arm || rsp_pending || exp_start) && c < budget) begin
            step();
            c++;
        end
        chk("drain_idle", m_busy, 1'b0);
    endtask

    task automatic stop_requests();
        pre();
        mode = MODE_HOLD;
        req_valid = '0;
        post();
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_status", rsp_status, '0);
        chk("rst_rsp_idx", rsp_idx, '0);
        chk("rst_mst_start", mst_start, 1'b0);
        chk("rst_mst_w_r", mst_w_r, 1'b0);
        chk("rst_mst_addr", mst_addr, '0);
        chk("rst_mst_data", mst_data, '0);
        chk("rst_mst_strb", mst_strb, '0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr = 0;
        exp_start = 1'b0;
        rsp_arm = 1'b0;
        rsp_pending = 1'b0;
        mm_state = 0;
        acc_last = '0;
        mst_rsp_valid = 1'b0;
        mst_free = 1'b1;
    endtask

    initial begin
        int c;
        repeat (3) @(negedge aclk);
        #1;
        check_reset_outputs();
        @(negedge aclk);
        areset = 1'b0;

        // All requesters busy from rr_ptr=0: strict 0,1,2,3 rotation.
        grant_q.delete();
        mode = MODE_ALL;
        wait_rsp(8, 400);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_q.size()) chk("t2_order", grant_q[k], k % NUM_REQ);
        end
        stop_requests();
        drain(100);

        // Single read from requester 2.
        fix_rsp = 1'b1;
        fix_lat = 3;
        fix_data = 64'h0000_0000_DEAD_BEEF;
        fix_stat = RESP_OKAY;
        pre();
        grant_q.delete();
        set_req(2, 1'b1, 32'h0000_0040, 64'h0, 8'h00);
        post();
        wait_rsp(1, 100);
        chk("t1_grant", grant_q[0], 2);

        // Pointer sits at 3: requester 3 beats requester 0.
        pre();
        grant_q.delete();
        set_req(0, 1'b1, 32'h0000_1000, 64'h0, 8'h00);
        set_req(3, 1'b1, 32'h0000_3000, 64'h0, 8'h00);
        post();
        wait_rsp(2, 200);
        chk("t4_first", grant_q[0], 3);
        chk("t4_second", grant_q[1], 0);

        // Write with partial strobe answered by SLVERR.
        fix_data = 64'h1234_5678_9ABC_DEF0;
        fix_stat = RESP_SLVERR;
        pre();
        grant_q.delete();
        set_req(1, 1'b0, 32'h0000_0100, 64'h0000_0000_CAFE_F00D, 8'h0F);
        post();
        wait_rsp(1, 100);
        chk("t3_grant", grant_q[0], 1);

        // Slow slave with everyone requesting: no extra start or accept.
        fix_lat = 10;
        fix_stat = RESP_OKAY;
        mode = MODE_ALL;
        wait_rsp(3, 300);
        stop_requests();
        drain(100);

        // Randomized traffic, latency, status and master availability.
        fix_rsp = 1'b0;
        free_rand = 1'b1;
        mode = MODE_RAND;
        repeat (3000) step();
        stop_requests();
        free_rand = 1'b0;
        drain(100);

        // Reset while waiting on the master, then a fresh arbitration from 0.
        fix_rsp = 1'b1;
        fix_lat = 10;
        pre();
        set_req(0, 1'b1, 32'h0000_0080, 64'h0, 8'h00);
        post();
        c = 0;
        while (mm_state != 2 && c < 20) begin
            step();
            c++;
        end
        chk("t6_in_wait", mm_state, 2);
        step();
        step();
        @(negedge aclk);
        areset = 1'b1;
        req_valid = '0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) begin
            @(negedge aclk);
            #1;
            chk("t6_no_rsp", rsp_valid, '0);
        end
        @(negedge aclk);
        areset = 1'b0;
        step();
        step();
        fix_lat = 2;
        pre();
        grant_q.delete();
        set_req(1, 1'b1, 32'h0000_0200, 64'h0, 8'h00);
        set_req(3, 1'b0, 32'h0000_0300, 64'h0000_0000_0000_00AA, 8'h01);
        post();
        wait_rsp(2, 200);
        chk("t6_first", grant_q[0], 1);
        chk("t6_second", grant_q[1], 3);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
